// File: rtl/spad_stream_ctrl.sv
// Scratchpad sequencer: loads one block from a stream, then replays it
// cfg_reuse times to the MAC side through a 2-entry output buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, cfg_len, cfg_reuse job launch and configuration (used in IDLE)
//   busy, done                job in progress / one-cycle end pulse
//   in_valid/in_ready/in_data load stream
//   out_valid/out_ready/out_data/out_last  output stream
//   sp_wen/sp_w_addr/sp_w_data SPad write port
//   sp_ren/sp_r_addr/sp_r_data SPad read port (data one cycle after ren)
module spad_stream_ctrl #(
    parameter int d_width = 32,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [a_width-1:0] cfg_len,
    input  logic [7:0]         cfg_reuse,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [d_width-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [d_width-1:0] out_data,
    output logic               out_last,
    output logic               sp_wen,
    output logic [a_width-1:0] sp_w_addr,
    output logic [d_width-1:0] sp_w_data,
    output logic               sp_ren,
    output logic [a_width-1:0] sp_r_addr,
    input  logic [d_width-1:0] sp_r_data
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_t;

    state_t             state;
    logic [a_width-1:0] len_q;
    logic [7:0]         reuse_q;
    logic [a_width-1:0] wptr;
    logic [a_width-1:0] rptr;
    logic [7:0]         pass;

    logic [d_width-1:0] buf_data [2];
    logic               buf_last [2];
    logic               head;
    logic               tail;
    logic [1:0]         count;
    logic               inflight;
    logic               inflight_last;

    logic wr;
    logic pop;
    logic ren;
    logic blk_end;
    logic last_rd;

    assign in_ready  = (state == LOAD);
    assign wr        = in_ready && in_valid;
    assign sp_wen    = wr;
    assign sp_w_addr = wr ? wptr : '0;
    assign sp_w_data = wr ? in_data : '0;

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? buf_data[head] : '0;
    assign out_last  = out_valid ? buf_last[head] : 1'b0;
    assign pop       = out_valid && out_ready;

    // A read may issue only if its word is guaranteed a buffer slot one
    // cycle later, counting the word still in flight and this cycle's pop.
    assign ren = (state == STREAM) &&
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign sp_ren    = ren;
    assign sp_r_addr = rptr;

    assign blk_end = (rptr == len_q - a_width'(1));
    assign last_rd = blk_end && (pass == reuse_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_q         <= '0;
            reuse_q       <= '0;
            wptr          <= '0;
            rptr          <= '0;
            pass          <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= ren;
            inflight_last <= ren && last_rd;

            // Word read last cycle lands in the buffer now.
            if (inflight) begin
                buf_data[tail] <= sp_r_data;
                buf_last[tail] <= inflight_last;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start && cfg_len != '0 && cfg_reuse != 8'd0) begin
                        len_q   <= cfg_len;
                        reuse_q <= cfg_reuse;
                        wptr    <= '0;
                        rptr    <= '0;
                        pass    <= '0;
                        state   <= LOAD;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr) begin
                        wptr <= wptr + a_width'(1);
                        if (wptr == len_q - a_width'(1)) begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (ren) begin
                        if (blk_end) begin
                            rptr <= '0;
                            pass <= pass + 8'd1;
                            if (last_rd) begin
                                state <= FLUSH;
                            end
                        end else begin
                            rptr <= rptr + a_width'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (pop && buf_last[head]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spad_stream_ctrl.sv
// Self-checking bench for spad_stream_ctrl: random load/drain traffic
// compared against an expected replay sequence built from the job config.
module tb_spad_stream_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_len;
    logic [7:0]    cfg_reuse;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          sp_wen;
    logic [AW-1:0] sp_w_addr;
    logic [DW-1:0] sp_w_data;
    logic          sp_ren;
    logic [AW-1:0] sp_r_addr;
    logic [DW-1:0] sp_r_data;

    spad_stream_ctrl #(.d_width(DW), .a_width(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_reuse(cfg_reuse),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .sp_wen(sp_wen), .sp_w_addr(sp_w_addr), .sp_w_data(sp_w_data),
        .sp_ren(sp_ren), .sp_r_addr(sp_r_addr), .sp_r_data(sp_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural scratchpad: one-cycle read latency.
    logic [DW-1:0] spad [256];
    always @(posedge clk) begin
        if (sp_wen) spad[sp_w_addr] <= sp_w_data;
        if (sp_ren) sp_r_data <= spad[sp_r_addr];
        else        sp_r_data <= $urandom;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [DW-1:0] din [256];
    int cyc_first_wr, cyc_first_pop, cyc_last_pop, cyc_done;

    // Entered at posedge+1. Returns at posedge+1, or at a negedge if
    // aborted (out_valid seen after at least one pop).
    task automatic run_job(input int len, input int reuse, input int vpct,
                           input int rpct, input bit restart_mid,
                           input bit abort, output bit aborted);
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        int  sent = 0, nrd = 0, npop = 0, occ = 0, maxocc = 0;
        int  both = 0, wr_err = 0, data_err = 0;
        bit  fin = 0, seen_done = 0;
        aborted = 0;
        for (int p = 0; p < reuse; p++)
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(din[i]);
                exp_l.push_back(p == reuse - 1 && i == len - 1);
            end
        cyc_first_wr = -1; cyc_first_pop = -1;
        cyc_last_pop = -1; cyc_done = -1;
        for (int k = 0; k < 3000 && !fin; k++) begin
            start     = (k == 0) || (restart_mid && k == 2);
            cfg_len   = (k == 0) ? AW'(len) : AW'(len + 1);
            cfg_reuse = (k == 0) ? 8'(reuse) : 8'(reuse + 1);
            in_valid  = (sent < len) && ($urandom_range(0, 99) < vpct);
            in_data   = in_valid ? din[sent] : $urandom;
            out_ready = $urandom_range(0, 99) < rpct;
            @(negedge clk);
            if (sp_wen && sp_ren) both++;
            if (in_valid && in_ready) begin
                if (!sp_wen || sp_w_addr != AW'(sent) ||
                    sp_w_data != din[sent]) wr_err++;
                if (cyc_first_wr < 0) cyc_first_wr = k;
                sent++;
            end else if (sp_wen) begin
                wr_err++;
            end
            if (sp_ren) nrd++;
            if (out_valid && out_ready) begin
                if (npop >= exp_d.size()) data_err++;
                else if (out_data != exp_d[npop] ||
                         out_last != exp_l[npop]) data_err++;
                if (cyc_first_pop < 0) cyc_first_pop = k;
                cyc_last_pop = k;
                npop++;
            end
            occ = nrd - npop;
            if (occ > maxocc) maxocc = occ;
            if (done) begin
                cyc_done  = k;
                seen_done = 1;
                fin       = 1;
                chk("busy_at_done", busy, 0);
            end
            if (abort && out_valid && npop > 0 && !fin) begin
                aborted = 1;
                fin     = 1;
                chk("pre_rst_valid", out_valid, 1);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        start    = 0;
        in_valid = 0;
        if (!aborted) begin
            chk("done_seen", seen_done, 1);
            chk("pop_cnt", npop, len * reuse);
            chk("rd_cnt", nrd, len * reuse);
            chk("data_seq", data_err, 0);
            chk("wr_port", wr_err, 0);
            chk("occ_le2", maxocc <= 2, 1);
            chk("wen_ren", both, 0);
        end
    endtask

    bit ab;

    initial begin
        rst = 1; start = 0; cfg_len = 0; cfg_reuse = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        @(posedge clk);
        #1;
        // Reset with random inputs, including valid starts.
        for (int i = 0; i < 3; i++) begin
            start     = 1;
            cfg_len   = AW'($urandom_range(1, 255));
            cfg_reuse = 8'($urandom_range(1, 255));
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_outs", {busy, done, in_ready, out_valid, out_last,
                sp_wen, sp_ren, |out_data, |sp_w_addr, |sp_r_addr,
                |sp_w_data}, 0);
            @(posedge clk);
            #1;
        end
        rst = 0; start = 0; in_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("idle_after_rst", {busy, in_ready}, 0);
        @(posedge clk);
        #1;

        // Basic job with timing.
        din[0] = 100; din[1] = 200; din[2] = 300; din[3] = 400;
        run_job(4, 1, 100, 100, 0, 0, ab);
        chk("t_first_wr", cyc_first_wr, 1);
        chk("t_first_out", cyc_first_pop, 7);
        chk("t_last_out", cyc_last_pop, 10);
        chk("t_done", cyc_done, 11);

        // Reuse.
        din[0] = 7; din[1] = 9;
        run_job(2, 3, 100, 100, 0, 0, ab);

        // Backpressure with input gaps.
        for (int i = 0; i < 5; i++) din[i] = $urandom;
        run_job(5, 2, 60, 50, 0, 0, ab);

        // Illegal starts.
        for (int i = 0; i < 2; i++) begin
            start     = 1;
            cfg_len   = (i == 0) ? AW'(0) : AW'(3);
            cfg_reuse = (i == 0) ? 8'd3 : 8'd0;
            @(posedge clk);
            #1;
            start = 0;
            @(negedge clk);
            chk("illegal_start", {busy, in_ready}, 0);
            @(posedge clk);
            #1;
        end

        // Second start during LOAD must not alter the job.
        for (int i = 0; i < 3; i++) din[i] = $urandom;
        run_job(3, 2, 100, 100, 1, 0, ab);

        // Reset in the middle of streaming, then a fresh job.
        for (int i = 0; i < 6; i++) din[i] = $urandom;
        run_job(6, 5, 100, 30, 0, 1, ab);
        chk("aborted", ab, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("mid_rst", {busy, out_valid, in_ready, sp_ren}, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) din[i] = $urandom;
        run_job(4, 2, 70, 60, 0, 0, ab);

        // Random jobs.
        for (int j = 0; j < 4; j++) begin
            int l, r;
            l = $urandom_range(1, 20);
            r = $urandom_range(1, 4);
            for (int i = 0; i < l; i++) din[i] = $urandom;
            run_job(l, r, $urandom_range(30, 100), $urandom_range(30, 100),
                    0, 0, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
